spi_cfg_responder: RTL
======================

Name: spi_cfg_responder

Overview:
- Chip-side SPI responder: the receiving end of the WETOP SPI master.
- Config mode (spi_sel=0): decodes 32-bit frames into a 16-entry x 24-bit register file and returns a full-duplex readback frame.
- Waveform mode (spi_sel=1): unpacks each 32-bit frame into two 16-bit DAC samples and buffers them in a FIFO.
- Runs in the weClk (512 kHz) domain. Replaces the dummy SPI model in system simulation and on-FPGA loopback.

Parameters:
- FRAME_W, 32, bits per frame. Frame layout: [31] wr, [30:24] addr, [23:0] data.
- NREG, 16, implemented registers at addresses 0..NREG-1.
- FIFO_DEPTH, 8, waveform FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock (weClk); must be >= 4x sclk.
- rst_n  in  1  asynchronous, active-low reset.
- spi_sel  in  1  frame type, sampled at frame start: 0 = config, 1 = waveform.
- cs_b  in  1  active-low chip select, asynchronous to clk.
- sclk  in  1  SPI clock, mode 0, asynchronous to clk.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- reg_wr  out  1  one-cycle pulse on a committed register write.
- reg_waddr  out  4  address of the committed write.
- reg_wdata  out  24  data of the committed write.
- rd_addr  in  4  combinational register-file read address (bench/DAC model).
- rd_data  out  24  contents of rf[rd_addr].
- wav_data  out  16  FIFO head.
- wav_valid  out  1  FIFO not empty.
- wav_ready  in  1  pop the FIFO when wav_valid & wav_ready.
- wav_overflow  out  1  sticky: a waveform frame was dropped.
- frame_err  out  1  one-cycle pulse on an aborted or overlong frame.
- frame_cnt  out  16  count of good committed frames, both modes; wraps.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rf all 0, resp_reg 0, FIFO empty, state IDLE.
  - All outputs 0.
- Synchronizers: cs_b, sclk and mosi each pass through 2 FFs. Edges are detected on the synced sclk and cs_b; all timing below is in synced cycles.
- FSM IDLE:
  - miso=0.
  - On synced cs_b fall: latch mode=spi_sel, bit_cnt=0, tx_sr=resp_reg, drive miso=tx_sr[31]; go to SHIFT.
- FSM SHIFT:
  - sclk rise: rx_sr={rx_sr[30:0], mosi_s}; bit_cnt++ (6-bit, saturates at 33).
  - sclk fall: tx_sr shifts left, miso=new tx_sr[31].
  - cs_b rise with bit_cnt==32 → COMMIT.
  - cs_b rise with any other bit_cnt → frame_err pulse, no side effects, go to IDLE.
- FSM COMMIT: exactly 1 cycle, then IDLE.
  - Config, wr=1, addr<NREG: rf[addr]<=data; reg_wr pulse with reg_waddr/reg_wdata; resp_reg<={1, addr, old rf[addr]}.
  - Config, wr=0, addr<NREG: resp_reg<={0, addr, rf[addr]}.
  - Config, addr>=NREG: no write; resp_reg<={wr, addr, 24'h0}. Still counts as a good frame.
  - Waveform, >= 2 free entries: push rx_sr[31:16], then rx_sr[15:0] (2 cycles allowed; FSM holds COMMIT for the second push).
  - Waveform, < 2 free entries: drop the whole frame, set wav_overflow. No partial push.
  - Waveform frames leave resp_reg unchanged.
  - frame_cnt++ on every good frame, including dropped waveform frames.
- Readback latency: the response to frame N is shifted out during frame N+1.
- FIFO:
  - Pop and push in the same cycle are both honoured; occupancy is unchanged.
  - Pop on empty is ignored. wav_data holds its last value when empty.
- wav_overflow clears only on reset.
- reg_wr latency: 1 clk after the synced cs_b rise, i.e. 3 clk after the raw cs_b rise.
- rst_n asserted mid-frame: immediate abort with no write. After release, wait for a new cs_b fall; a cs_b already low at release is ignored until it rises.
- sclk edges while in IDLE (cs_b high) are ignored.

Test Plan:
- Write then read: frame 0x85_ABCDEF (wr, addr 5), then 0x05_000000 → rf[5]=0xABCDEF; reg_wr pulse with reg_waddr=5; second frame's miso returns 0x85000000; a third frame returns 0x05ABCDEF.
- Bad address: write 0x9F_123456 (addr 0x1F) → no reg_wr; rd_data unchanged for all addresses; next miso returns 0x9F000000; frame_cnt increments.
- Aborted frame: cs_b rises after 17 sclk → frame_err pulses once; rf and frame_cnt unchanged; 33-sclk frame → frame_err.
- Waveform: spi_sel=1, frames 0x11112222 then 0x33334444 with wav_ready=0 → 4 entries; drain pops 0x1111, 0x2222, 0x3333, 0x4444 in order.
- Overflow: FIFO_DEPTH=8 holding 7 entries, send a waveform frame → dropped, occupancy stays 7, wav_overflow=1; pop 1 and resend → accepted, occupancy 8.
- Reset mid-frame: rst_n low after 10 bits of a write to addr 3 → rf[3]=0, miso=0, no reg_wr; the next complete frame works normally.

Source files
------------

// File: rtl/spi_cfg_responder.sv
// Chip-side SPI mode-0 responder: config frames go to a 16x24 register file with
// full-duplex readback, waveform frames are split into two DAC samples and queued in a FIFO.
module spi_cfg_responder #(
    parameter int unsigned FRAME_W    = 32,
    parameter int unsigned NREG       = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sel,
    input  logic        cs_b,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        reg_wr,
    output logic [3:0]  reg_waddr,
    output logic [23:0] reg_wdata,
    input  logic [3:0]  rd_addr,
    output logic [23:0] rd_data,
    output logic [15:0] wav_data,
    output logic        wav_valid,
    input  logic        wav_ready,
    output logic        wav_overflow,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 24;
    localparam int unsigned SW = 16;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t               state;
    logic                 cs_q1, cs_q2, cs_q3;
    logic                 sclk_q1, sclk_q2, sclk_q3;
    logic                 mosi_q1, mosi_q2;
    logic                 mode;
    logic [5:0]           bit_cnt;
    logic [FRAME_W-1:0]   rx_sr;
    logic [FRAME_W-1:0]   tx_sr;
    logic [FRAME_W-1:0]   resp_reg;
    logic                 push_lo;
    logic [DW-1:0]        rf [NREG];
    logic [SW-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        cnt;

    logic                 cs_fall_c, cs_rise_c, sclk_rise_c, sclk_fall_c;
    logic                 good_end_c, cfg_addr_ok_c, fifo_room_c;
    logic [AW-1:0]        idx_c;
    logic                 push_c, pop_c;
    logic [SW-1:0]        push_data_c;
    logic [CW-1:0]        cnt_n_c;
    logic [PW-1:0]        rd_n_c;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {cs_q3, cs_q2, cs_q1}       <= 3'b000;
            {sclk_q3, sclk_q2, sclk_q1} <= 3'b000;
            {mosi_q2, mosi_q1}          <= 2'b00;
        end else begin
            {cs_q3, cs_q2, cs_q1}       <= {cs_q2, cs_q1, cs_b};
            {sclk_q3, sclk_q2, sclk_q1} <= {sclk_q2, sclk_q1, sclk};
            {mosi_q2, mosi_q1}          <= {mosi_q1, mosi};
        end
    end

    always_comb begin
        cs_fall_c     = cs_q3 & ~cs_q2;
        cs_rise_c     = ~cs_q3 & cs_q2;
        sclk_rise_c   = ~sclk_q3 & sclk_q2;
        sclk_fall_c   = sclk_q3 & ~sclk_q2;
        good_end_c    = (state == SHIFT) && cs_rise_c && (bit_cnt == 6'(FRAME_W));
        cfg_addr_ok_c = rx_sr[30:24] < 7'(NREG);
        idx_c         = rx_sr[24 +: AW];
        fifo_room_c   = cnt <= CW'(FIFO_DEPTH - 2);
        push_c        = (good_end_c && mode && fifo_room_c) || ((state == COMMIT) && push_lo);
        push_data_c   = (state == COMMIT) ? rx_sr[SW-1:0] : rx_sr[FRAME_W-1 -: SW];
        pop_c         = wav_valid & wav_ready;
        cnt_n_c       = cnt + CW'(push_c) - CW'(pop_c);
        rd_n_c        = rd_ptr + PW'(pop_c);
        rd_data       = rf[rd_addr];
    end

    // Frame FSM; the commit side effects land on the SHIFT->COMMIT edge, COMMIT carries the low sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mode         <= 1'b0;
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            resp_reg     <= '0;
            push_lo      <= 1'b0;
            miso         <= 1'b0;
            reg_wr       <= 1'b0;
            reg_waddr    <= '0;
            reg_wdata    <= '0;
            wav_overflow <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else begin
            reg_wr    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall_c) begin
                        mode    <= spi_sel;
                        bit_cnt <= '0;
                        tx_sr   <= resp_reg;
                        miso    <= resp_reg[FRAME_W-1];
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise_c) begin
                        rx_sr <= {rx_sr[FRAME_W-2:0], mosi_q2};
                        if (bit_cnt != 6'(FRAME_W + 1)) bit_cnt <= bit_cnt + 6'd1;
                    end
                    if (sclk_fall_c) begin
                        tx_sr <= tx_sr << 1;
                        miso  <= tx_sr[FRAME_W-2];
                    end
                    if (cs_rise_c) begin
                        miso <= 1'b0;
                        if (good_end_c) begin
                            state     <= COMMIT;
                            frame_cnt <= frame_cnt + 16'd1;
                            push_lo   <= 1'b0;
                            if (mode) begin
                                if (fifo_room_c) push_lo <= 1'b1;
                                else wav_overflow <= 1'b1;
                            end else if (cfg_addr_ok_c) begin
                                resp_reg <= {rx_sr[31], rx_sr[30:24], rf[idx_c]};
                                if (rx_sr[31]) begin
                                    rf[idx_c] <= rx_sr[DW-1:0];
                                    reg_wr    <= 1'b1;
                                    reg_waddr <= idx_c;
                                    reg_wdata <= rx_sr[DW-1:0];
                                end
                            end else begin
                                resp_reg <= {rx_sr[31], rx_sr[30:24], 24'h0};
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    push_lo <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= push_data_c;
    end

    // FIFO pointers; wav_data is a registered head that bypasses a push into an emptying FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            wav_valid <= 1'b0;
            wav_data  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr    <= rd_n_c;
            cnt       <= cnt_n_c;
            wav_valid <= cnt_n_c != '0;
            if (push_c && ((cnt - CW'(pop_c)) == '0)) wav_data <= push_data_c;
            else if (cnt_n_c != '0) wav_data <= mem[rd_n_c];
        end
    end

endmodule
